// File: rtl/ls_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : ls_mem_unit
// Description : Load/store memory responder. It has dual-lane loads with
//               store-buffer forwarding and an in-order store buffer that
//               retires into RAM on commit.
// Revision    : 1.0 - initial release
// ============================================================================
module ls_mem_unit #(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 10,
    parameter int SB_DEPTH = 4,
    parameter int TAG_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      disp1,
    input  logic                      mem_write_in,
    input  logic [DATA_W-1:0]         address_in,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [TAG_W-1:0]          dest_in,
    input  logic [TAG_W-1:0]          sw_tag_in,
    input  logic                      disp2,
    input  logic                      mem_write_in2,
    input  logic [DATA_W-1:0]         address_in2,
    input  logic [DATA_W-1:0]         data_in2,
    input  logic [TAG_W-1:0]          dest_in2,
    input  logic [TAG_W-1:0]          sw_tag_in2,
    input  logic                      commit_sw1,
    input  logic                      commit_sw2,
    output logic                      ld_write,
    output logic                      ld_write2,
    output logic [TAG_W-1:0]          ld_tag,
    output logic [TAG_W-1:0]          ld_tag2,
    output logic [DATA_W-1:0]         ld_res,
    output logic [DATA_W-1:0]         ld_res2,
    output logic                      sw_retire,
    output logic [TAG_W-1:0]          sw_retire_tag,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_full,
    output logic                      sb_overflow
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(SB_DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);

    logic [DATA_W-1:0]   r_ram [0:(1<<IDX_W)-1];
    logic [SB_DEPTH-1:0] r_sb_valid;
    logic [IDX_W-1:0]    r_sb_idx  [SB_DEPTH];
    logic [DATA_W-1:0]   r_sb_data [SB_DEPTH];
    logic [TAG_W-1:0]    r_sb_tag  [SB_DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;

    logic [IDX_W-1:0]  w_idx1, w_idx2;
    logic              w_ld1, w_ld2, w_st1, w_st2;
    logic              w_deq1, w_deq2, w_acc1, w_acc2;
    logic [PTR_W-1:0]  w_head1, w_tail2, w_p;
    logic [CNT_W-1:0]  w_free;
    logic [DATA_W-1:0] w_ld_data1, w_ld_data2;

    // Byte offset and high address bits alias onto the same word.
    logic w_unused_addr;
    assign w_unused_addr = ^{address_in[1:0], address_in[DATA_W-1:IDX_W+2],
                             address_in2[1:0], address_in2[DATA_W-1:IDX_W+2]};

    assign w_idx1  = address_in[IDX_W+1:2];
    assign w_idx2  = address_in2[IDX_W+1:2];
    assign w_ld1   = disp1 & ~mem_write_in;
    assign w_st1   = disp1 &  mem_write_in;
    assign w_ld2   = disp2 & ~mem_write_in2;
    assign w_st2   = disp2 &  mem_write_in2;

    assign w_deq1  = commit_sw1 && (r_count != '0);
    assign w_deq2  = commit_sw1 && commit_sw2 && (r_count >= C_TWO);
    assign w_head1 = r_head + PTR_W'(1);

    // Space freed by this cycle's commits is available to this cycle's stores.
    assign w_free  = C_DEPTH - r_count + CNT_W'(w_deq1) + CNT_W'(w_deq2);
    assign w_acc1  = w_st1 && (w_free >= C_ONE);
    assign w_acc2  = w_st2 && (w_free >= (w_acc1 ? C_TWO : C_ONE));
    assign w_tail2 = r_tail + PTR_W'(w_acc1);

    assign sb_count = r_count;
    assign sb_full  = (r_count > (C_DEPTH - C_TWO));

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        w_ld_data1 = r_ram[w_idx1];
        w_ld_data2 = r_ram[w_idx2];
        w_p        = r_head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_p = r_head + PTR_W'(i);
            if (r_sb_valid[w_p] && (r_sb_idx[w_p] == w_idx1))
                w_ld_data1 = r_sb_data[w_p];
            if (r_sb_valid[w_p] && (r_sb_idx[w_p] == w_idx2))
                w_ld_data2 = r_sb_data[w_p];
        end
        if (w_st1 && (w_idx1 == w_idx2))
            w_ld_data2 = data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_write      <= 1'b0;
            ld_write2     <= 1'b0;
            ld_tag        <= '0;
            ld_tag2       <= '0;
            ld_res        <= '0;
            ld_res2       <= '0;
            sw_retire     <= 1'b0;
            sw_retire_tag <= '0;
            sb_overflow   <= 1'b0;
            r_sb_valid    <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
        end else begin
            ld_write  <= w_ld1;
            ld_tag    <= w_ld1 ? dest_in : '0;
            ld_res    <= w_ld1 ? w_ld_data1 : '0;
            ld_write2 <= w_ld2;
            ld_tag2   <= w_ld2 ? dest_in2 : '0;
            ld_res2   <= w_ld2 ? w_ld_data2 : '0;

            sw_retire     <= w_deq1;
            sw_retire_tag <= w_deq2 ? r_sb_tag[w_head1] :
                             (w_deq1 ? r_sb_tag[r_head] : '0);

            // Frees come first so a same-cycle enqueue into a freed slot sticks.
            if (w_deq1) r_sb_valid[r_head]  <= 1'b0;
            if (w_deq2) r_sb_valid[w_head1] <= 1'b0;
            if (w_acc1) r_sb_valid[r_tail]  <= 1'b1;
            if (w_acc2) r_sb_valid[w_tail2] <= 1'b1;

            r_head  <= r_head + PTR_W'(w_deq1) + PTR_W'(w_deq2);
            r_tail  <= r_tail + PTR_W'(w_acc1) + PTR_W'(w_acc2);
            r_count <= r_count + CNT_W'(w_acc1) + CNT_W'(w_acc2)
                               - CNT_W'(w_deq1) - CNT_W'(w_deq2);

            if ((w_st1 && !w_acc1) || (w_st2 && !w_acc2))
                sb_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_acc1) begin
                r_sb_idx[r_tail]  <= w_idx1;
                r_sb_data[r_tail] <= data_in;
                r_sb_tag[r_tail]  <= sw_tag_in;
            end
            if (w_acc2) begin
                r_sb_idx[w_tail2]  <= w_idx2;
                r_sb_data[w_tail2] <= data_in2;
                r_sb_tag[w_tail2]  <= sw_tag_in2;
            end
        end
    end

    // Second write is later in program order, so it wins on a shared word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_deq1) r_ram[r_sb_idx[r_head]]  <= r_sb_data[r_head];
            if (w_deq2) r_ram[r_sb_idx[w_head1]] <= r_sb_data[w_head1];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ls_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ls_mem_unit
// Description : Bench for ls_mem_unit. It uses a vector table, directed
//               corner sequences and random traffic against a queue-based
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_mem_unit;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 10;
    localparam int DEPTH  = 4;
    localparam int TAG_W  = 5;

    logic clk = 1'b0;
    logic rst;
    logic d1, w1, d2, w2, c1, c2;
    logic [DATA_W-1:0] a1, dt1, a2, dt2;
    logic [TAG_W-1:0]  dst1, tg1, dst2, tg2;

    logic              ld_write, ld_write2, sw_retire, sb_full, sb_overflow;
    logic [TAG_W-1:0]  ld_tag, ld_tag2, sw_retire_tag;
    logic [DATA_W-1:0] ld_res, ld_res2;
    logic [$clog2(DEPTH):0] sb_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ls_mem_unit #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SB_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .disp1(d1), .mem_write_in(w1), .address_in(a1), .data_in(dt1),
        .dest_in(dst1), .sw_tag_in(tg1),
        .disp2(d2), .mem_write_in2(w2), .address_in2(a2), .data_in2(dt2),
        .dest_in2(dst2), .sw_tag_in2(tg2),
        .commit_sw1(c1), .commit_sw2(c2),
        .ld_write(ld_write), .ld_write2(ld_write2), .ld_tag(ld_tag), .ld_tag2(ld_tag2),
        .ld_res(ld_res), .ld_res2(ld_res2), .sw_retire(sw_retire),
        .sw_retire_tag(sw_retire_tag), .sb_count(sb_count), .sb_full(sb_full),
        .sb_overflow(sb_overflow)
    );

    // ---------------- reference model ----------------
    typedef struct { int idx; logic [DATA_W-1:0] data; logic [TAG_W-1:0] tag; } st_t;
    st_t               m_q[$];
    logic [DATA_W-1:0] m_ram [int];
    logic              m_ovf = 1'b0;
    logic              e_ldw, e_ldw2, e_ret;
    logic              e_k1, e_k2;
    logic [TAG_W-1:0]  e_tag, e_tag2, e_rtag;
    logic [DATA_W-1:0] e_res, e_res2;

    function automatic int widx(logic [DATA_W-1:0] a);
        return int'((a >> 2) % (1 << IDX_W));
    endfunction

    task automatic lookup(input int idx, output logic known, output logic [DATA_W-1:0] v);
        known = 1'b0;
        v     = '0;
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].idx == idx) begin
                known = 1'b1;
                v     = m_q[i].data;
                return;
            end
        if (m_ram.exists(idx)) begin
            known = 1'b1;
            v     = m_ram[idx];
        end
    endtask

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int n, cap;
        e_k1 = 1'b1; e_k2 = 1'b1;
        e_ldw = 0; e_tag = '0; e_res = '0; e_ldw2 = 0; e_tag2 = '0; e_res2 = '0;
        e_ret = 0; e_rtag = '0;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        if (d1 && !w1) begin
            e_ldw = 1; e_tag = dst1;
            lookup(widx(a1), e_k1, e_res);
        end
        if (d2 && !w2) begin
            e_ldw2 = 1; e_tag2 = dst2;
            if (d1 && w1 && widx(a1) == widx(a2)) e_res2 = dt1;
            else lookup(widx(a2), e_k2, e_res2);
        end
        n = c1 ? (c2 ? 2 : 1) : 0;
        if (n > m_q.size()) n = m_q.size();
        for (int i = 0; i < n; i++) begin
            st_t s = m_q.pop_front();
            m_ram[s.idx] = s.data;
            e_ret  = 1;
            e_rtag = s.tag;
        end
        cap = DEPTH - m_q.size();
        if (d1 && w1) begin
            if (cap > 0) begin m_q.push_back('{widx(a1), dt1, tg1}); cap--; end
            else m_ovf = 1'b1;
        end
        if (d2 && w2) begin
            if (cap > 0) m_q.push_back('{widx(a2), dt2, tg2});
            else m_ovf = 1'b1;
        end
    endtask

    // One clock: model predicts, edge happens, outputs checked 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("ld_write",  ld_write,  e_ldw);
        chk("ld_tag",    ld_tag,    e_tag);
        if (e_k1) chk("ld_res", ld_res, e_res);
        chk("ld_write2", ld_write2, e_ldw2);
        chk("ld_tag2",   ld_tag2,   e_tag2);
        if (e_k2) chk("ld_res2", ld_res2, e_res2);
        chk("sw_retire",     sw_retire,     e_ret);
        chk("sw_retire_tag", sw_retire_tag, e_rtag);
        chk("sb_count",      sb_count,      m_q.size());
        chk("sb_full",       sb_full,       (m_q.size() > DEPTH - 2));
        chk("sb_overflow",   sb_overflow,   m_ovf);
    endtask

    task automatic idle();
        rst = 0; d1 = 0; w1 = 0; d2 = 0; w2 = 0; c1 = 0; c2 = 0;
        a1 = '0; dt1 = '0; dst1 = '0; tg1 = '0;
        a2 = '0; dt2 = '0; dst2 = '0; tg2 = '0;
    endtask

    task automatic st1(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
        d1 = 1; w1 = 1; a1 = a; dt1 = d; tg1 = t;
    endtask
    task automatic st2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
        d2 = 1; w2 = 1; a2 = a; dt2 = d; tg2 = t;
    endtask
    task automatic ld1(input logic [DATA_W-1:0] a, input logic [TAG_W-1:0] t);
        d1 = 1; w1 = 0; a1 = a; dst1 = t;
    endtask
    task automatic ld2(input logic [DATA_W-1:0] a, input logic [TAG_W-1:0] t);
        d2 = 1; w2 = 0; a2 = a; dst2 = t;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic d1, w1; logic [31:0] a1, dt1; logic [4:0] dst1, tg1;
        logic d2, w2; logic [31:0] a2, dt2; logic [4:0] dst2, tg2;
        logic c1, c2;
        logic e_ldw;  logic [4:0] e_tag;  logic [31:0] e_res;
        logic e_ldw2; logic [4:0] e_tag2; logic [31:0] e_res2;
        logic e_ret;  logic [4:0] e_rtag; logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt [18];

    initial begin
        vt[0]  = '{1,1,'h10,'hDEADBEEF,0,1, 0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,1};
        vt[1]  = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,1,0};
        vt[2]  = '{1,0,'h10,0,7,0,          0,0,0,0,0,0, 0,0, 1,7,'hDEADBEEF, 0,0,0, 0,0,0};
        vt[3]  = '{0,0,0,0,0,0,             0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0};
        vt[4]  = '{1,1,'h20,'h8888,0,2,     0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,1};
        vt[5]  = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,2,0};
        vt[6]  = '{1,1,'h20,'h1234,0,3,     0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,1};
        vt[7]  = '{1,0,'h22,0,9,0,          0,0,0,0,0,0, 0,0, 1,9,'h1234, 0,0,0, 0,0,1};
        vt[8]  = '{0,0,0,0,0,0,             1,0,'h1020,0,10,0, 0,0, 0,0,0, 1,10,'h1234, 0,0,1};
        vt[9]  = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,0, 0,0,0, 0,0,0, 1,3,0};
        vt[10] = '{1,0,'h20,0,4,0,          0,0,0,0,0,0, 0,0, 1,4,'h1234, 0,0,0, 0,0,0};
        vt[11] = '{1,1,'h40,'hA,0,5,        1,1,'h40,'hB,0,6, 0,0, 0,0,0, 0,0,0, 0,0,2};
        vt[12] = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,1, 0,0,0, 0,0,0, 1,6,0};
        vt[13] = '{1,0,'h40,0,11,0,         0,0,0,0,0,0, 0,0, 1,11,'hB, 0,0,0, 0,0,0};
        vt[14] = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,1, 0,0,0, 0,0,0, 0,0,0};
        vt[15] = '{1,1,'h80,'h77,0,8,       0,0,0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,1};
        vt[16] = '{0,0,0,0,0,0,             0,0,0,0,0,0, 0,1, 0,0,0, 0,0,0, 0,0,1};
        vt[17] = '{0,0,0,0,0,0,             0,0,0,0,0,0, 1,1, 0,0,0, 0,0,0, 1,8,0};
    end

    // ---------------- test sequence ----------------
    initial begin
        idle();
        rst = 1;
        cycle();
        cycle();
        chk("reset_count", sb_count, 0);
        chk("reset_ovf",   sb_overflow, 0);
        idle();

        for (int i = 0; i < 18; i++) begin
            d1 = vt[i].d1; w1 = vt[i].w1; a1 = vt[i].a1; dt1 = vt[i].dt1;
            dst1 = vt[i].dst1; tg1 = vt[i].tg1;
            d2 = vt[i].d2; w2 = vt[i].w2; a2 = vt[i].a2; dt2 = vt[i].dt2;
            dst2 = vt[i].dst2; tg2 = vt[i].tg2;
            c1 = vt[i].c1; c2 = vt[i].c2;
            cycle();
            chk($sformatf("vec%0d_ldw", i),   ld_write,      vt[i].e_ldw);
            chk($sformatf("vec%0d_tag", i),   ld_tag,        vt[i].e_tag);
            chk($sformatf("vec%0d_res", i),   ld_res,        vt[i].e_res);
            chk($sformatf("vec%0d_ldw2", i),  ld_write2,     vt[i].e_ldw2);
            chk($sformatf("vec%0d_tag2", i),  ld_tag2,       vt[i].e_tag2);
            chk($sformatf("vec%0d_res2", i),  ld_res2,       vt[i].e_res2);
            chk($sformatf("vec%0d_ret", i),   sw_retire,     vt[i].e_ret);
            chk($sformatf("vec%0d_rtag", i),  sw_retire_tag, vt[i].e_rtag);
            chk($sformatf("vec%0d_cnt", i),   sb_count,      vt[i].e_cnt);
        end
        idle();

        // Fill to DEPTH-1, enqueue two alongside a commit, then overflow.
        st1('h100, 'h100, 12); st2('h104, 'h104, 13); cycle(); idle();
        st1('h108, 'h108, 14); cycle(); idle();
        chk("t4_full", sb_full, 1);
        chk("t4_cnt3", sb_count, 3);
        st1('h10C, 'h10C, 15); st2('h110, 'h110, 16); c1 = 1; cycle(); idle();
        chk("t4_cnt4", sb_count, 4);
        chk("t4_noovf", sb_overflow, 0);
        chk("t4_ret12", sw_retire_tag, 12);
        st1('h114, 'h114, 17); cycle(); idle();
        chk("t4_ovf", sb_overflow, 1);
        chk("t4_cnt_hold", sb_count, 4);
        c1 = 1; c2 = 1; cycle(); cycle(); idle();
        chk("t4_drain", sb_count, 0);
        chk("t4_lasttag", sw_retire_tag, 16);

        // Lane-2 load on neighbour word, then same-word forward both ways.
        st1('h64, 'h2525, 1); cycle(); idle(); c1 = 1; cycle(); idle();
        st1('h60, 'h55, 17); ld2('h64, 18); cycle(); idle();
        chk("t5_ram25", ld_res2, 'h2525);
        ld1('h60, 19); cycle(); idle();
        chk("t5_fwd", ld_res, 'h55);
        st1('h60, 'h66, 20); ld2('h63, 21); cycle(); idle();
        chk("t5_samecyc", ld_res2, 'h66);
        c1 = 1; c2 = 1; cycle(); idle();

        // Reset drops buffered stores and the in-flight load.
        st1('h200, 'h11, 1); cycle(); idle(); c1 = 1; cycle(); idle();
        st1('h200, 'h99, 20); st2('h204, 'h98, 21); cycle(); idle();
        ld1('h200, 22); rst = 1; cycle(); idle();
        chk("t6_ldw", ld_write, 0);
        chk("t6_cnt", sb_count, 0);
        chk("t6_ovf", sb_overflow, 0);
        c1 = 1; cycle(); idle();
        chk("t6_noret", sw_retire, 0);
        ld1('h200, 23); cycle(); idle();
        chk("t6_ram", ld_res, 'h11);

        // Seed a small word window, then random traffic against the model.
        for (int w = 0; w < 16; w += 2) begin
            st1(w * 4, $urandom, 5'(w)); st2(w * 4 + 4, $urandom, 5'(w + 1)); cycle(); idle();
            c1 = 1; c2 = 1; cycle(); idle();
        end
        for (int i = 0; i < 400; i++) begin
            idle();
            rst = ($urandom_range(0, 63) == 0);
            d1 = $urandom_range(0, 1); d2 = $urandom_range(0, 1);
            w1 = $urandom_range(0, 1); w2 = $urandom_range(0, 1);
            if (m_q.size() > DEPTH - 2) begin w1 = 0; w2 = 0; end
            a1 = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            a2 = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            dt1 = $urandom; dt2 = $urandom;
            dst1 = 5'($urandom); dst2 = 5'($urandom);
            tg1 = 5'($urandom); tg2 = 5'($urandom);
            c1 = ($urandom_range(0, 9) < 6); c2 = $urandom_range(0, 1);
            cycle();
        end
        idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
